// File: rtl/j_sched_pkg.sv
// Shared types and helpers for the latch write scheduler.
package j_sched_pkg;

  // Widest requester set the round-robin picker handles.
  localparam int MAX_NREQ = 8;
  localparam int PTR_W    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } state_e;

  // First set bit of req at or after ptr, wrapping. Requests above NREQ are
  // zero-padded by the caller, so wrapping modulo MAX_NREQ is equivalent to
  // wrapping modulo NREQ. Result is only meaningful when req is non-zero.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                               input logic [PTR_W-1:0]    ptr);
    logic [PTR_W-1:0] idx;
    rr_pick = ptr;
    // Scan farthest-first so the nearest set bit is the last one written.
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      idx = ptr + PTR_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/j_rr_arb.sv
// Round-robin picker: combinational pick from the current pointer, plus the
// pointer register that moves past the requester once its write completes.
module j_rr_arb
  import j_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            adv_i,
  input  logic [IW-1:0]   adv_idx_i,
  output logic [IW-1:0]   gnt_idx_o,
  output logic            gnt_vld_o
);

  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_d;
  logic [PTR_W-1:0] pick;

  assign pick      = rr_pick(MAX_NREQ'(req_i), PTR_W'(ptr_q));
  assign gnt_idx_o = IW'(pick);
  assign gnt_vld_o = |req_i;

  // Next pointer: one past the requester just served, modulo NREQ.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      if (adv_idx_i == IW'(NREQ - 1)) ptr_d = '0;
      else                            ptr_d = adv_idx_i + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/j_latch_wr_sched.sv
// Latch-bank write scheduler: arbitrates NREQ requesters onto the shared latch
// d bus, then issues a setup cycle followed by a one-cycle enable strobe.
//
//   state  | meaning
//   IDLE   | waiting; latch_d holds last value, capture on any request
//   SETUP  | latch_d driven with captured data, no enable
//   STROBE | latch_en[addr] and ack[gnt] high for this cycle only
module j_latch_wr_sched
  import j_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NLAT = 16,
  parameter int DW   = 16,
  parameter int AW   = 4
) (
  input  logic               sys_clk_i,
  input  logic               reset_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  output logic [NREQ-1:0]    ack_o,
  output logic [DW-1:0]      latch_d_o,
  output logic [NLAT-1:0]    latch_en_o,
  output logic               busy_o,
  output logic               err_addr_o
);

  localparam int IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   latch_d_q, latch_d_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NLAT-1:0] latch_en_q, latch_en_d;
  logic            busy_q, busy_d;
  logic            err_addr_q, err_addr_d;

  logic [IW-1:0]   arb_idx;
  logic            arb_vld;
  logic            addr_ok;
  logic [AW-1:0]   addr_arr [NREQ];
  logic [DW-1:0]   data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign addr_arr[g] = req_addr_i[g*AW +: AW];
    assign data_arr[g] = req_data_i[g*DW +: DW];
  end

  j_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .clk_i     (sys_clk_i),
    .rst_i     (reset_i),
    .req_i     (req_i),
    .adv_i     (state_q == STROBE),
    .adv_idx_i (gnt_q),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  assign addr_ok = ({1'b0, addr_q} < (AW+1)'(NLAT));

  // Next state and next registered outputs; strobe and ack are computed in
  // SETUP so they appear registered during STROBE.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    latch_d_d  = latch_d_q;
    ack_d      = '0;
    latch_en_d = '0;
    busy_d     = 1'b0;
    err_addr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          gnt_d     = arb_idx;
          addr_d    = addr_arr[arb_idx];
          latch_d_d = data_arr[arb_idx];
          busy_d    = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        busy_d        = 1'b1;
        ack_d[gnt_q]  = 1'b1;
        state_d       = STROBE;
        if (addr_ok) begin
          for (int i = 0; i < NLAT; i++) latch_en_d[i] = (addr_q == AW'(i));
        end else begin
          err_addr_d = 1'b1;
        end
      end
      STROBE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, holding and output registers; reset clears the strobe at once.
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      addr_q     <= '0;
      latch_d_q  <= '0;
      ack_q      <= '0;
      latch_en_q <= '0;
      busy_q     <= 1'b0;
      err_addr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      latch_d_q  <= latch_d_d;
      ack_q      <= ack_d;
      latch_en_q <= latch_en_d;
      busy_q     <= busy_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign ack_o      = ack_q;
  assign latch_d_o  = latch_d_q;
  assign latch_en_o = latch_en_q;
  assign busy_o     = busy_q;
  assign err_addr_o = err_addr_q;

endmodule
